// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared compare-mode encodings, FSM states and mode helpers
// Ports: none (package). Imported by slice_cmp and slice_cmp_unit.
package cmp_pkg;

  // Compare mode encoding (3 bits).
  localparam logic [2:0] CMP_EQ  = 3'd0;
  localparam logic [2:0] CMP_NE  = 3'd1;
  localparam logic [2:0] CMP_LTS = 3'd2;
  localparam logic [2:0] CMP_GES = 3'd3;
  localparam logic [2:0] CMP_LTU = 3'd4;
  localparam logic [2:0] CMP_GEU = 3'd5;
  localparam logic [2:0] CMP_LEZ = 3'd6;
  localparam logic [2:0] CMP_GTZ = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Signed modes flip the sign bit of the top slice so an unsigned
  // slice compare orders two's-complement values correctly.
  function automatic logic is_signed(input logic [2:0] mode);
    return (mode == CMP_LTS) || (mode == CMP_GES) ||
           (mode == CMP_LEZ) || (mode == CMP_GTZ);
  endfunction

  // Zero modes compare A against 0; operand B is discarded.
  function automatic logic is_zero_mode(input logic [2:0] mode);
    return (mode == CMP_LEZ) || (mode == CMP_GTZ);
  endfunction

  // Map the accumulated eq/lt flags onto the single branch outcome.
  function automatic logic eval_result(input logic [2:0] mode,
                                       input logic       eq,
                                       input logic       lt);
    logic r;
    r = 1'b0;
    case (mode)
      CMP_EQ:  r = eq;
      CMP_NE:  r = !eq;
      CMP_LTS: r = lt;
      CMP_GES: r = !lt;
      CMP_LTU: r = lt;
      CMP_GEU: r = !lt;
      CMP_LEZ: r = lt | eq;
      CMP_GTZ: r = !(lt | eq);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/slice_cmp.sv
// rtl/slice_cmp.sv - combinational CHUNK-bit slice comparator
// Ports:
//   slice_a    in  CHUNK  slice of operand A
//   slice_b    in  CHUNK  slice of operand B
//   signed_top in  1      slice holds the operand sign bit and mode is signed
//   diff       out 1      slices differ
//   lt         out 1      slice A orders below slice B (after sign adjustment)
module slice_cmp #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] slice_a,
  input  logic [CHUNK-1:0] slice_b,
  input  logic             signed_top,
  output logic             diff,
  output logic             lt
);

  // Mask of the slice MSB; an XOR keeps this valid even for CHUNK == 1.
  localparam logic [CHUNK-1:0] MSB_MASK = {1'b1, {(CHUNK-1){1'b0}}};

  logic [CHUNK-1:0] adj_a;
  logic [CHUNK-1:0] adj_b;

  always_comb begin
    adj_a = slice_a ^ (signed_top ? MSB_MASK : '0);
    adj_b = slice_b ^ (signed_top ? MSB_MASK : '0);
    // Flipping the same bit on both sides never changes equality.
    diff  = (adj_a != adj_b);
    lt    = (adj_a < adj_b);
  end

endmodule

// File: rtl/slice_cmp_unit.sv
// rtl/slice_cmp_unit.sv - multi-cycle slice-serial compare engine (MSB slice first)
// Ports:
//   clk     in  1      clock, rising edge
//   reset   in  1      synchronous active-high reset
//   start   in  1      request, sampled only while ready
//   mode    in  3      compare mode, latched with start
//   a       in  WIDTH  operand A, latched with start
//   b       in  WIDTH  operand B, latched with start (zero modes use 0)
//   ready   out 1      idle, able to accept start
//   busy    out 1      running or presenting a result
//   done    out 1      one-cycle pulse, result/eq_o/lt_o valid
//   result  out 1      mode-evaluated outcome, held until next done
//   eq_o    out 1      a == b, held until next done
//   lt_o    out 1      a < b (signed/unsigned per mode), held until next done
module slice_cmp_unit #(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             result,
  output logic             eq_o,
  output logic             lt_o
);

  import cmp_pkg::*;

  localparam int NSLICE = WIDTH / CHUNK;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] TOP_IDX = IDXW'(NSLICE - 1);

  generate
    if ((WIDTH % CHUNK) != 0 || NSLICE < 1) begin : g_bad_params
      $error("slice_cmp_unit: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  state_t           state_q,   state_d;
  logic [WIDTH-1:0] a_q,       a_d;
  logic [WIDTH-1:0] b_q,       b_d;
  logic [2:0]       mode_q,    mode_d;
  logic [IDXW-1:0]  idx_q,     idx_d;
  logic             decided_q, decided_d;
  logic             lt_acc_q,  lt_acc_d;
  logic             result_q,  result_d;
  logic             eq_q,      eq_d;
  logic             lt_q,      lt_d;

  logic [CHUNK-1:0] cur_a;
  logic [CHUNK-1:0] cur_b;
  logic             cur_signed_top;
  logic             cur_diff;
  logic             cur_lt;
  logic             first_diff;
  logic             last_slice;
  logic             fin_eq;
  logic             fin_lt;

  // Slice currently under compare; b_q is already zero for zero modes.
  always_comb begin
    cur_a          = a_q[idx_q*CHUNK +: CHUNK];
    cur_b          = b_q[idx_q*CHUNK +: CHUNK];
    cur_signed_top = is_signed(mode_q) && (idx_q == TOP_IDX);
  end

  slice_cmp #(
    .CHUNK (CHUNK)
  ) u_slice_cmp (
    .slice_a    (cur_a),
    .slice_b    (cur_b),
    .signed_top (cur_signed_top),
    .diff       (cur_diff),
    .lt         (cur_lt)
  );

  // The most significant differing slice decides ordering; later slices
  // only matter for equality, which is already false once decided.
  always_comb begin
    first_diff = cur_diff && !decided_q;
    last_slice = (idx_q == '0);
    fin_eq     = !(decided_q || cur_diff);
    fin_lt     = first_diff ? cur_lt : lt_acc_q;
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    mode_d    = mode_q;
    idx_d     = idx_q;
    decided_d = decided_q;
    lt_acc_d  = lt_acc_q;
    result_d  = result_q;
    eq_d      = eq_q;
    lt_d      = lt_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d       = a;
          b_d       = is_zero_mode(mode) ? '0 : b;
          mode_d    = mode;
          idx_d     = TOP_IDX;
          decided_d = 1'b0;
          lt_acc_d  = 1'b0;
          state_d   = S_RUN;
        end
      end

      S_RUN: begin
        if (first_diff) begin
          decided_d = 1'b1;
          lt_acc_d  = cur_lt;
        end
        if (last_slice || ((EARLY_EXIT != 0) && first_diff)) begin
          // Held outputs change only here, on entry to DONE.
          eq_d     = fin_eq;
          lt_d     = fin_lt;
          result_d = eval_result(mode_q, fin_eq, fin_lt);
          state_d  = S_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= '0;
      idx_q     <= '0;
      decided_q <= 1'b0;
      lt_acc_q  <= 1'b0;
      result_q  <= 1'b0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mode_q    <= mode_d;
      idx_q     <= idx_d;
      decided_q <= decided_d;
      lt_acc_q  <= lt_acc_d;
      result_q  <= result_d;
      eq_q      <= eq_d;
      lt_q      <= lt_d;
    end
  end

  assign ready  = (state_q == S_IDLE);
  assign busy   = (state_q == S_RUN) || (state_q == S_DONE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign eq_o   = eq_q;
  assign lt_o   = lt_q;

endmodule

// File: tb/tb_slice_cmp_unit.sv
// tb/tb_slice_cmp_unit.sv - scoreboard bench for three slice_cmp_unit configurations
module tb_slice_cmp_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  start_v;
  logic [2:0]  mode;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  ready_v, busy_v, done_v, result_v, eq_v, lt_v;

  always #5 clk = ~clk;

  // 0: CHUNK=8 early exit, 1: CHUNK=8 full run, 2: CHUNK=32 single slice
  slice_cmp_unit #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1)) u_early (
    .clk(clk), .reset(reset), .start(start_v[0]), .mode(mode), .a(a), .b(b),
    .ready(ready_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .result(result_v[0]), .eq_o(eq_v[0]), .lt_o(lt_v[0]));

  slice_cmp_unit #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(0)) u_full (
    .clk(clk), .reset(reset), .start(start_v[1]), .mode(mode), .a(a), .b(b),
    .ready(ready_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .result(result_v[1]), .eq_o(eq_v[1]), .lt_o(lt_v[1]));

  slice_cmp_unit #(.WIDTH(32), .CHUNK(32), .EARLY_EXIT(1)) u_wide (
    .clk(clk), .reset(reset), .start(start_v[2]), .mode(mode), .a(a), .b(b),
    .ready(ready_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .result(result_v[2]), .eq_o(eq_v[2]), .lt_o(lt_v[2]));

  typedef struct {
    logic res;
    logic eq;
    logic lt;
    int   due;
  } exp_t;

  exp_t exp_q[3][$];
  int   pass_cnt = 0;
  int   chk_cnt  = 0;
  int   cyc      = 0;
  logic [2:0] last_res = 3'b000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int chunk_of(input int i);
    return (i == 2) ? 32 : 8;
  endfunction

  function automatic int early_of(input int i);
    return (i == 1) ? 0 : 1;
  endfunction

  // Reference: whole-word arithmetic on the architectural values.
  function automatic void model(input logic [2:0] m, input logic [31:0] av, input logic [31:0] bv,
                                output logic res, output logic eq, output logic lt);
    logic [31:0] bb;
    logic        sgn;
    bb  = (m == 3'd6 || m == 3'd7) ? 32'd0 : bv;
    sgn = (m == 3'd2 || m == 3'd3 || m == 3'd6 || m == 3'd7);
    eq  = (av == bb);
    lt  = sgn ? ($signed(av) < $signed(bb)) : (av < bb);
    case (m)
      3'd0: res = eq;
      3'd1: res = !eq;
      3'd2, 3'd4: res = lt;
      3'd3, 3'd5: res = !lt;
      3'd6: res = lt | eq;
      default: res = !(lt | eq);
    endcase
  endfunction

  // Cycles from the start edge to the edge that enters DONE.
  function automatic int model_lat(input logic [2:0] m, input logic [31:0] av, input logic [31:0] bv,
                                   input int chunk, input int early);
    int          ns;
    logic [31:0] bb;
    logic [63:0] mask;
    logic [63:0] sa;
    logic [63:0] sb;
    ns   = 32 / chunk;
    bb   = (m == 3'd6 || m == 3'd7) ? 32'd0 : bv;
    mask = (64'd1 << chunk) - 64'd1;
    if (early == 0) return ns;
    for (int j = 1; j <= ns; j++) begin
      sa = ({32'd0, av} >> ((ns - j) * chunk)) & mask;
      sb = ({32'd0, bb} >> ((ns - j) * chunk)) & mask;
      if (sa != sb) return j;
    end
    return ns;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (done_v[i]) begin
        if (exp_q[i].size() == 0) begin
          check($sformatf("unexpected_done[%0d]", i), {31'd0, done_v[i]}, 32'd0);
        end else begin
          e = exp_q[i].pop_front();
          check($sformatf("result[%0d]", i), {31'd0, result_v[i]}, {31'd0, e.res});
          check($sformatf("eq_o[%0d]", i), {31'd0, eq_v[i]}, {31'd0, e.eq});
          check($sformatf("lt_o[%0d]", i), {31'd0, lt_v[i]}, {31'd0, e.lt});
          check($sformatf("done_cycle[%0d]", i), cyc, e.due);
          check($sformatf("busy_in_done[%0d]", i), {30'd0, busy_v[i], ready_v[i]}, 32'd2);
        end
      end else if (exp_q[i].size() > 0 && cyc > exp_q[i][0].due) begin
        check($sformatf("done_late[%0d]", i), cyc, exp_q[i][0].due);
        void'(exp_q[i].pop_front());
      end
    end
  end

  // Wait (at negedges) until every instance is idle with nothing outstanding.
  task automatic wait_idle();
    int n;
    n = 0;
    while ((ready_v != 3'b111 || exp_q[0].size() != 0 || exp_q[1].size() != 0 ||
            exp_q[2].size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (ready_v != 3'b111) check("ready_timeout", {29'd0, ready_v}, 32'd7);
    for (int i = 0; i < 3; i++) exp_q[i].delete();
  endtask

  // Issue one op to all instances; returns at the negedge after the start edge.
  task automatic do_op(input logic [2:0] m, input logic [31:0] av, input logic [31:0] bv);
    exp_t e;
    int   k;
    wait_idle();
    mode    = m;
    a       = av;
    b       = bv;
    start_v = 3'b111;
    @(posedge clk);
    @(negedge clk);
    start_v = 3'b000;
    k = cyc;
    check("busy_after_start", {29'd0, busy_v}, 32'd7);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("result_hold[%0d]", i), {31'd0, result_v[i]}, {31'd0, last_res[i]});
      model(m, av, bv, e.res, e.eq, e.lt);
      e.due = k + model_lat(m, av, bv, chunk_of(i), early_of(i));
      exp_q[i].push_back(e);
      last_res[i] = e.res;
    end
  endtask

  logic [31:0] ra, rb;
  int          sel;
  logic [31:0] corner [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset   = 1'b1;
    start_v = 3'b000;
    mode    = 3'd0;
    a       = 32'd0;
    b       = 32'd0;
    corner  = '{32'h0, 32'h1, 32'h80000000, 32'h7fffffff, 32'hffffffff};
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_ready",  {29'd0, ready_v},  32'd7);
    check("reset_busy",   {29'd0, busy_v},   32'd0);
    check("reset_done",   {29'd0, done_v},   32'd0);
    check("reset_result", {29'd0, result_v}, 32'd0);
    check("reset_eq",     {29'd0, eq_v},     32'd0);
    check("reset_lt",     {29'd0, lt_v},     32'd0);

    // Directed cases.
    do_op(3'd0, 32'h12345678, 32'h12345678);   // EQ, full run everywhere
    do_op(3'd2, 32'hFFFFFFFF, 32'h00000001);   // LTS, exits on MSB slice
    do_op(3'd4, 32'hFFFFFFFF, 32'h00000001);   // LTU
    do_op(3'd7, 32'h00000001, 32'hDEADBEEF);   // GTZ, b ignored
    do_op(3'd6, 32'h80000000, 32'h00000000);   // LEZ
    do_op(3'd3, 32'h7FFFFFFF, 32'h80000000);   // GES across the sign
    do_op(3'd1, 32'h00000100, 32'h00000100);   // NE equal operands

    // LTU with start held high through the run on the slice-serial units.
    do_op(3'd4, 32'h00000010, 32'h00000020);
    a       = 32'd0;
    b       = 32'd0;
    mode    = 3'd0;
    start_v = 3'b011;
    repeat (4) @(negedge clk);
    check("held_done_pulse", {31'd0, done_v[0]}, 32'd1);
    start_v = 3'b000;
    @(negedge clk);
    check("held_ready_after_done", {31'd0, ready_v[0]}, 32'd1);
    check("held_done_one_cycle", {31'd0, done_v[0]}, 32'd0);

    // Reset during the second RUN cycle of an EQ op aborts it.
    do_op(3'd0, 32'h12345678, 32'h12345678);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) exp_q[i].delete();
    last_res = 3'b000;
    check("abort_ready",  {29'd0, ready_v},  32'd7);
    check("abort_busy",   {29'd0, busy_v},   32'd0);
    check("abort_done",   {29'd0, done_v},   32'd0);
    check("abort_result", {29'd0, result_v}, 32'd0);
    do_op(3'd1, 32'h00000001, 32'h00000002);   // fresh NE after abort

    // Randomized ops biased toward equal, near-equal and corner operands.
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 3);
      ra  = $urandom;
      rb  = $urandom;
      case (sel)
        0: rb = ra;
        1: rb = ra ^ (32'd1 << $urandom_range(0, 31));
        3: begin
          ra = corner[$urandom_range(0, 4)];
          rb = ($urandom_range(0, 1) == 1) ? corner[$urandom_range(0, 4)] : ra;
        end
        default: ;
      endcase
      do_op(3'($urandom_range(0, 7)), ra, rb);
    end

    wait_idle();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
